// File: rtl/rv32i_lsu_ctrl.sv
// RV32I load/store controller: one memory op at a time over a req/gnt/rvalid data bus.
// Optional macro RV32I_LSU_MISALIGN_EXC_EN traps misaligned HALF/WORD accesses before the bus.
module rv32i_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_error_o,
  output logic              rsp_misaligned_o,
  output logic              busy_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               write_q, uns_q;
  logic [1:0]         size_q, off_q;
  logic [4:0]         rd_q;
  logic               dmem_req_q, dmem_we_q;
  logic [ADDR_W-1:0]  dmem_addr_q;
  logic [3:0]         dmem_be_q;
  logic [31:0]        dmem_wdata_q;
  logic               rsp_valid_q, rsp_error_q, rsp_mis_q;
  logic [31:0]        rsp_rdata_q;

  // Decode of the incoming request, used only on the accept edge.
  logic [1:0]  acc_off;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        acc_reserved, acc_misaligned;
  // Load lane extraction from the live bus word using the latched request.
  logic [31:0] ld_shift, ld_data;
  logic        timeout_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_off        = 2'b00;
    acc_be         = 4'b1111;
    acc_wdata      = req_wdata_i;
    acc_reserved   = 1'b0;
    acc_misaligned = 1'b0;
    case (req_size_i)
      SZ_BYTE: begin
        acc_off   = req_addr_i[1:0];
        acc_be    = 4'b0001 << req_addr_i[1:0];
        acc_wdata = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        acc_off   = {req_addr_i[1], 1'b0};
        acc_be    = 4'b0011 << {req_addr_i[1], 1'b0};
        acc_wdata = {2{req_wdata_i[15:0]}};
      end
      SZ_WORD: ;
      default: acc_reserved = 1'b1;
    endcase
`ifdef RV32I_LSU_MISALIGN_EXC_EN
    acc_misaligned = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                     ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    acc_misaligned = 1'b0;
`endif

    ld_shift = dmem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: ld_data = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_mis_q    <= 1'b0;
      rsp_rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          cnt_q   <= '0;
          write_q <= req_write_i;
          uns_q   <= req_unsigned_i;
          size_q  <= req_size_i;
          off_q   <= acc_off;
          rd_q    <= req_write_i ? 5'd0 : req_rd_i;
          if (acc_reserved || acc_misaligned) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= acc_reserved;
            rsp_mis_q   <= acc_misaligned & ~acc_reserved;
            rsp_rdata_q <= 32'd0;
          end else begin
            state_q      <= S_REQ;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= req_write_i;
            dmem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
            dmem_be_q    <= acc_be;
            dmem_wdata_q <= acc_wdata;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= S_WAIT;
          end else if (timeout_hit) begin
            dmem_req_q  <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem_rvalid_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= dmem_err_i;
            rsp_rdata_q <= (dmem_err_i || write_q) ? 32'd0 : ld_data;
          end else if (timeout_hit) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_mis_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_rd_o         = rd_q;
  assign rsp_error_o      = rsp_error_q;
  assign rsp_misaligned_o = rsp_mis_q;
  assign dmem_req_o       = dmem_req_q;
  assign dmem_we_o        = dmem_we_q;
  assign dmem_addr_o      = dmem_addr_q;
  assign dmem_be_o        = dmem_be_q;
  assign dmem_wdata_o     = dmem_wdata_q;

endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
// Directed bench for rv32i_lsu_ctrl: loads, stores, bus error, timeout, misaligned and mid-access reset.
module tb_rv32i_lsu_ctrl;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o, rsp_error_o, rsp_misaligned_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic        o_req, o_we, o_stable, o_req_after_gnt;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic        o_rsp_valid, o_err, o_mis, o_rsp_ready, o_after_valid, o_after_ready;
  logic [4:0]  o_rd;
  int          o_cyc;

  always #5 clk = ~clk;

  rv32i_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
    .rsp_error_o(rsp_error_o), .rsp_misaligned_o(rsp_misaligned_o), .busy_o(busy_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; inputs change only at negedges.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gnt_dly, input logic [31:0] bus_rdata, input logic bus_err);
    int cyc;
    req_valid_i = 1'b1; req_write_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1;
    o_req = dmem_req_o; o_addr = dmem_addr_o; o_be = dmem_be_o; o_we = dmem_we_o;
    o_wdata = dmem_wdata_o; o_stable = 1'b1; o_req_after_gnt = 1'b0;
    if (dmem_req_o) begin
      for (int k = 0; k < gnt_dly; k++) begin
        @(negedge clk);
        cyc++;
        if (!dmem_req_o || dmem_addr_o !== o_addr || dmem_be_o !== o_be ||
            dmem_wdata_o !== o_wdata || dmem_we_o !== o_we) o_stable = 1'b0;
      end
      // A stray rvalid in the grant cycle must be ignored.
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_0BAD;
      @(negedge clk);
      cyc++;
      o_req_after_gnt = dmem_req_o;
      dmem_gnt_i = 1'b0; dmem_rdata_i = bus_rdata; dmem_err_i = bus_err;
      @(negedge clk);
      cyc++;
      dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 32'h0;
    end
    while (!rsp_valid_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    o_cyc = cyc; o_rsp_valid = rsp_valid_o; o_rdata = rsp_rdata_o; o_rd = rsp_rd_o;
    o_err = rsp_error_o; o_mis = rsp_misaligned_o; o_rsp_ready = req_ready_o;
    @(negedge clk);
    o_after_valid = rsp_valid_o; o_after_ready = req_ready_o;
  endtask

  initial begin
    int req_cycles;
    int cyc;
    logic seen;
    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0; dmem_err_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_be_addr", {dmem_be_o, dmem_addr_o[27:0]}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // LW 0x100, minimum latency
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 1'b0);
    check("lw_req", {31'd0, o_req}, 32'd1);
    check("lw_addr", o_addr, 32'h100);
    check("lw_be", {28'd0, o_be}, 32'hF);
    check("lw_we", {31'd0, o_we}, 32'd0);
    check("lw_req_drop_after_gnt", {31'd0, o_req_after_gnt}, 32'd0);
    check("lw_latency", o_cyc, 32'd3);
    check("lw_rdata", o_rdata, 32'hDEAD_BEEF);
    check("lw_rd", {27'd0, o_rd}, 32'd5);
    check("lw_ready_in_resp", {31'd0, o_rsp_ready}, 32'd0);
    check("lw_pulse_one_cycle", {31'd0, o_after_valid}, 32'd0);
    check("lw_ready_after", {31'd0, o_after_ready}, 32'd1);

    // LB / LBU from byte lane 3
    run_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 5'd6, 0, 32'h80FF_FF7F, 1'b0);
    check("lb_be", {28'd0, o_be}, 32'h8);
    check("lb_addr", o_addr, 32'h200);
    check("lb_rdata", o_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 5'd6, 0, 32'h80FF_FF7F, 1'b0);
    check("lbu_rdata", o_rdata, 32'h0000_0080);

    // LH from upper half, sign extended
    run_op(1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 5'd3, 0, 32'h8001_1234, 1'b0);
    check("lh_be", {28'd0, o_be}, 32'hC);
    check("lh_rdata", o_rdata, 32'hFFFF_8001);
    run_op(1'b0, 2'b01, 1'b1, 32'h400, 32'h0, 5'd3, 0, 32'h8001_F234, 1'b0);
    check("lhu_rdata", o_rdata, 32'h0000_F234);

    // SH / SB stores: replicated data, rdata and rd zero
    run_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234_ABCD, 5'd7, 0, 32'hFFFF_FFFF, 1'b0);
    check("sh_be", {28'd0, o_be}, 32'hC);
    check("sh_wdata", o_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'd0, o_we}, 32'd1);
    check("sh_rdata", o_rdata, 32'd0);
    check("sh_rd", {27'd0, o_rd}, 32'd0);
    check("sh_valid", {31'd0, o_rsp_valid}, 32'd1);
    run_op(1'b1, 2'b00, 1'b0, 32'h001, 32'h0000_00AB, 5'd1, 0, 32'h0, 1'b0);
    check("sb_be", {28'd0, o_be}, 32'h2);
    check("sb_wdata", o_wdata, 32'hABAB_ABAB);

    // Grant withheld 5 cycles, then bus error
    run_op(1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFE_F00D, 5'd0, 5, 32'h1234_5678, 1'b1);
    check("err_stable", {31'd0, o_stable}, 32'd1);
    check("err_latency", o_cyc, 32'd8);
    check("err_flag", {31'd0, o_err}, 32'd1);
    check("err_rdata", o_rdata, 32'd0);
    run_op(1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 5'd9, 2, 32'h1234_5678, 1'b1);
    check("lerr_flag", {31'd0, o_err}, 32'd1);
    check("lerr_rdata", o_rdata, 32'd0);
    check("lerr_rd", {27'd0, o_rd}, 32'd9);

    // Reserved size: no bus request, immediate error
    run_op(1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 5'd4, 0, 32'h0, 1'b0);
    check("rsv_no_req", {31'd0, o_req}, 32'd0);
    check("rsv_latency", o_cyc, 32'd1);
    check("rsv_err", {31'd0, o_err}, 32'd1);
    check("rsv_mis", {31'd0, o_mis}, 32'd0);

    // Misaligned LW 0x101
    run_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd8, 0, 32'h1122_3344, 1'b0);
`ifdef RV32I_LSU_MISALIGN_EXC_EN
    check("mis_no_req", {31'd0, o_req}, 32'd0);
    check("mis_flag", {31'd0, o_mis}, 32'd1);
    check("mis_err", {31'd0, o_err}, 32'd0);
    check("mis_rdata", o_rdata, 32'd0);
`else
    check("mis_addr", o_addr, 32'h100);
    check("mis_be", {28'd0, o_be}, 32'hF);
    check("mis_rdata", o_rdata, 32'h1122_3344);
    check("mis_flag", {31'd0, o_mis}, 32'd0);
`endif

    // Timeout: grant never comes
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h700; req_rd_i = 5'd2;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1; req_cycles = 0;
    while (!rsp_valid_o && cyc < 200) begin
      if (dmem_req_o) req_cycles++;
      @(negedge clk);
      cyc++;
    end
    check("to_rsp_seen", {31'd0, rsp_valid_o}, 32'd1);
    check("to_req_window", {31'd0, (req_cycles >= TO && req_cycles <= TO + 1)}, 32'd1);
    check("to_err", {31'd0, rsp_error_o}, 32'd1);
    check("to_req_dropped", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (rsp_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    check("to_late_rvalid_ignored", {31'd0, seen}, 32'd0);

    // Reset while in WAIT
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h800; req_rd_i = 5'd11;
    @(negedge clk);
    req_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    check("rstw_in_wait", {31'd0, busy_o & ~dmem_req_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rstw_ready", {31'd0, req_ready_o}, 32'd1);
    check("rstw_req", {31'd0, dmem_req_o}, 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (rsp_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    check("rstw_no_rsp", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
